// File: rtl/fb_sched_pkg.sv
// Shared constants for the framebuffer write scheduler: FSM encoding, source
// indexing and the underrun fill colour.
package fb_sched_pkg;

  localparam int N_SRC     = 2;
  localparam int SRC_IDX_W = 1;

  typedef logic [SRC_IDX_W-1:0] src_idx_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_VSYNC  = 2'd2;

  // Wide enough for any pixel format; the top truncates it to COLOR_BITS.
  localparam logic [63:0] FILL_COLOR = 64'd0;

  function automatic logic [N_SRC-1:0] src_onehot(input logic [SRC_IDX_W-1:0] idx);
    src_onehot      = '0;
    src_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/fb_rr_arbiter2.sv
// Two-way round-robin frame arbiter; with both sources requesting, the one
// that did not win last time is chosen.
module fb_rr_arbiter2
  import fb_sched_pkg::*;
(
  input  logic [1:0]           req,
  input  logic [SRC_IDX_W-1:0] rr_last,
  input  logic                 strobe,
  output logic [1:0]           grant,
  output logic [SRC_IDX_W-1:0] idx
);

  always_comb begin
    idx   = '0;
    grant = 2'b00;
    if (strobe) begin
      case (req)
        2'b01:   idx = 1'b0;
        2'b10:   idx = 1'b1;
        2'b11:   idx = ~rr_last;
        default: idx = 1'b0;
      endcase
      if (req != 2'b00) begin
        grant = src_onehot(idx);
      end
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Frame-granular scheduler sharing the sequential framebuffer write port between
// two pixel sources. Optional underrun fill: define FB_UNDERRUN_FILL_EN.
module fb_write_scheduler
  import fb_sched_pkg::*;
#(
  parameter int WIDTH          = 640,
  parameter int HEIGHT         = 480,
  parameter int COLOR_BITS     = 18,
  parameter int PIXEL_INTERVAL = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [1:0]              req,
  output logic [1:0]              grant,
  input  logic [1:0]              src_valid,
  input  logic [2*COLOR_BITS-1:0] src_data,
  output logic [1:0]              src_ready,
  output logic                    fb_we,
  output logic [COLOR_BITS-1:0]   fb_data,
  output logic                    fb_vsync,
  output logic                    busy,
  output logic [15:0]             frame_cnt
`ifdef FB_UNDERRUN_FILL_EN
  ,
  output logic [15:0]             underrun_cnt
`endif
);

  localparam int XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PACE_W = 8;

  localparam logic [XW-1:0]     X_LAST      = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST      = YW'(HEIGHT - 1);
  localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(PIXEL_INTERVAL - 1);

  logic [1:0]            state_q;
  logic [1:0]            grant_q;
  src_idx_t              gidx_q;
  src_idx_t              rr_last_q;
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic [PACE_W-1:0]     pace_q;
  logic [15:0]           frame_cnt_q;

  logic                  vld_p1;
  logic [COLOR_BITS-1:0] pix_p1;
  logic                  vsync_p1;

  logic [1:0]            arb_grant;
  src_idx_t              arb_idx;
  logic                  arb_strobe;
  logic                  slot_open;
  logic                  cur_valid;
  logic [COLOR_BITS-1:0] cur_pix;
  logic [COLOR_BITS-1:0] wr_pix;
  logic                  accept;
  logic                  fill;
  logic                  advance;

  fb_rr_arbiter2 u_arb (
    .req     (req),
    .rr_last (rr_last_q),
    .strobe  (arb_strobe),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );

  assign arb_strobe = (state_q == ST_IDLE) && enable;

  // Pixel slot opens only for the granted source once the pacing timer expires.
  assign slot_open = (state_q == ST_STREAM) && enable && (pace_q == '0);
  assign src_ready = slot_open ? grant_q : 2'b00;
  assign cur_valid = src_valid[gidx_q];
  assign cur_pix   = gidx_q[0] ? src_data[2*COLOR_BITS-1:COLOR_BITS]
                               : src_data[COLOR_BITS-1:0];
  assign accept    = slot_open && cur_valid;
  assign advance   = accept || fill;
  assign wr_pix    = accept ? cur_pix : COLOR_BITS'(FILL_COLOR);

`ifdef FB_UNDERRUN_FILL_EN
  logic [PACE_W-1:0] wait_q;
  logic [15:0]       underrun_q;

  // A starved slot is filled after PIXEL_INTERVAL idle cycles to hold frame rate.
  assign fill = slot_open && !cur_valid && (wait_q == PACE_W'(PIXEL_INTERVAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q     <= '0;
      underrun_q <= '0;
    end else begin
      if (slot_open && !cur_valid && !fill) begin
        wait_q <= wait_q + PACE_W'(1);
      end else begin
        wait_q <= '0;
      end
      if (fill && (underrun_q != 16'hFFFF)) begin
        underrun_q <= underrun_q + 16'd1;
      end
    end
  end

  assign underrun_cnt = underrun_q;
`else
  assign fill = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      gidx_q      <= '0;
      rr_last_q   <= 1'b1;
      x_q         <= '0;
      y_q         <= '0;
      pace_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (advance) begin
        pace_q <= PACE_RELOAD;
      end else if (pace_q != '0) begin
        pace_q <= pace_q - PACE_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (arb_grant != 2'b00) begin
            state_q   <= ST_STREAM;
            grant_q   <= arb_grant;
            gidx_q    <= arb_idx;
            rr_last_q <= arb_idx;
          end
        end
        ST_STREAM: begin
          if (advance) begin
            if (x_q == X_LAST) begin
              x_q <= '0;
              if (y_q == Y_LAST) begin
                y_q     <= '0;
                state_q <= ST_VSYNC;
              end else begin
                y_q <= y_q + YW'(1);
              end
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        ST_VSYNC: begin
          state_q     <= ST_IDLE;
          grant_q     <= 2'b00;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stage p1: registered write strobe, pixel and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      pix_p1   <= '0;
      vsync_p1 <= 1'b0;
    end else begin
      vld_p1   <= advance;
      vsync_p1 <= (state_q == ST_VSYNC);
      if (advance) begin
        pix_p1 <= wr_pix;
      end
    end
  end

  assign fb_we     = vld_p1;
  assign fb_data   = pix_p1;
  assign fb_vsync  = vsync_p1;
  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule
